// File: rtl/keypad_pkg.sv
// Shared constants, FSM states and coordinate helpers for the keypad entry path.
package keypad_pkg;

   localparam logic [3:0] KEY_BACKSPACE = 4'hE;
   localparam logic [3:0] KEY_ENTER     = 4'hF;

   localparam int unsigned DEF_SETTLE_CYCLES  = 3_000_000;
   localparam int unsigned DEF_RELEASE_CYCLES = 1_000_000;
   localparam int unsigned DEF_DIGITS         = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CAPTURE,
      ST_HOLD,
      ST_RELEASE
   } kp_state_t;

   // {valid, index}: a legal nibble has exactly one zero; 0111 is index 0
   function automatic logic [2:0] nibble_index(input logic [3:0] nib);
      case (nib)
         4'b0111: nibble_index = 3'b100;
         4'b1011: nibble_index = 3'b101;
         4'b1101: nibble_index = 3'b110;
         4'b1110: nibble_index = 3'b111;
         default: nibble_index = 3'b000;
      endcase
   endfunction

   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      case ({row, col})
         4'b00_00: key_map = 4'h1;
         4'b00_01: key_map = 4'h2;
         4'b00_10: key_map = 4'h3;
         4'b00_11: key_map = 4'hA;
         4'b01_00: key_map = 4'h4;
         4'b01_01: key_map = 4'h5;
         4'b01_10: key_map = 4'h6;
         4'b01_11: key_map = 4'hB;
         4'b10_00: key_map = 4'h7;
         4'b10_01: key_map = 4'h8;
         4'b10_10: key_map = 4'h9;
         4'b10_11: key_map = 4'hC;
         4'b11_00: key_map = KEY_BACKSPACE;
         4'b11_01: key_map = 4'h0;
         4'b11_10: key_map = KEY_ENTER;
         default:  key_map = 4'hD;
      endcase
   endfunction

endpackage

// File: rtl/keypad_entry_buffer_if.sv
// CPU-side valid/ack handoff of a completed keypad entry.
interface keypad_entry_buffer_if
   import keypad_pkg::*;
#(
   parameter int unsigned DIGITS = DEF_DIGITS
);
   logic [4*DIGITS-1:0] data_out;
   logic                data_valid;
   logic                data_ack;

   modport master (output data_out, output data_valid, input data_ack);
   modport slave  (input data_out, input data_valid, output data_ack);
endinterface

// File: rtl/keypad_coord_decoder.sv
// Combinational {row,col} active-low coordinate to 4-bit key code decoder.
module keypad_coord_decoder
   import keypad_pkg::*;
(
   input  logic [7:0] key_coord,
   output logic       legal,
   output logic [3:0] code
);
   logic [2:0] row_sel;
   logic [2:0] col_sel;

   always_comb begin
      row_sel = nibble_index(key_coord[7:4]);
      col_sel = nibble_index(key_coord[3:0]);
      legal   = row_sel[2] & col_sel[2];
      code    = key_map(row_sel[1:0], col_sel[1:0]);
   end
endmodule

// File: rtl/keypad_entry_buffer.sv
// Debounced keypad press capture, hex entry accumulation and CPU handoff.
module keypad_entry_buffer
   import keypad_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int unsigned RELEASE_CYCLES = DEF_RELEASE_CYCLES,
   parameter int unsigned DIGITS         = DEF_DIGITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          key_coord,
   input  logic                key_active,
   output logic [3:0]          key_code,
   output logic                key_strobe,
   output logic [4*DIGITS-1:0] entry_value,
   output logic [3:0]          digit_count,
   output logic                overflow,
   output logic                bad_key,
   keypad_entry_buffer_if.master cpu
);
   localparam int unsigned MAX_CYC = (SETTLE_CYCLES > RELEASE_CYCLES) ? SETTLE_CYCLES : RELEASE_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);
   localparam logic [3:0]       DIGIT_MAX    = 4'(DIGITS);

   kp_state_t        state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;

   logic       legal;
   logic [3:0] code;
   logic       capture;
   logic       room;
   logic       have_digits;
   logic       enter_ok;

   keypad_coord_decoder u_decoder (
      .key_coord (key_coord),
      .legal     (legal),
      .code      (code)
   );

   assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // The IDLE sample that leaves IDLE already counts as the first high sample
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      unique case (state)
         ST_IDLE: begin
            cnt_d = '0;
            if (key_active) begin
               cnt_d   = CNT_W'(1);
               state_d = (SETTLE_CYCLES <= 1) ? ST_CAPTURE : ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (!key_active) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt >= SETTLE_LAST) begin
               state_d = ST_CAPTURE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_CAPTURE: state_d = ST_HOLD;
         ST_HOLD: begin
            if (!key_active) begin
               state_d = ST_RELEASE;
               cnt_d   = '0;
            end
         end
         ST_RELEASE: begin
            if (key_active) begin
               state_d = ST_HOLD;
            end else if (cnt >= RELEASE_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      capture     = (state == ST_CAPTURE);
      room        = (digit_count < DIGIT_MAX);
      have_digits = (digit_count != '0);
      enter_ok    = capture && legal && (code == KEY_ENTER) && have_digits &&
                    (!cpu.data_valid || cpu.data_ack);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_code       <= '0;
         key_strobe     <= 1'b0;
         entry_value    <= '0;
         digit_count    <= '0;
         overflow       <= 1'b0;
         bad_key        <= 1'b0;
         cpu.data_out   <= '0;
         cpu.data_valid <= 1'b0;
      end else begin
         key_strobe <= 1'b0;
         overflow   <= 1'b0;
         bad_key    <= 1'b0;
         if (capture) begin
            if (!legal) begin
               bad_key <= 1'b1;
            end else begin
               key_strobe <= 1'b1;
               key_code   <= code;
               if (code == KEY_BACKSPACE) begin
                  if (have_digits) begin
                     entry_value <= {4'h0, entry_value[4*DIGITS-1:4]};
                     digit_count <= digit_count - 1'b1;
                  end
               end else if (code == KEY_ENTER) begin
                  if (enter_ok) begin
                     entry_value <= '0;
                     digit_count <= '0;
                  end
               end else if (room) begin
                  entry_value <= {entry_value[4*DIGITS-5:0], code};
                  digit_count <= digit_count + 1'b1;
               end else begin
                  overflow <= 1'b1;
               end
            end
         end
         // A new accepted entry wins over an ack arriving in the same cycle
         if (enter_ok) begin
            cpu.data_out   <= entry_value;
            cpu.data_valid <= 1'b1;
         end else if (cpu.data_ack) begin
            cpu.data_valid <= 1'b0;
         end
      end
   end
endmodule
